// File: rtl/bench_vector_driver.sv
// -----------------------------------------------------------------------------
// bench_vector_driver
//
// Sequential stimulus/response front end for a combinational benchmark
// netlist. The driver collects one input vector serially, presents it on a
// parallel bus, waits for the netlist to settle, captures the netlist outputs
// and streams them back serially. Only one vector is in flight at a time.
//
// Ports
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous, active-high reset
//   s_in_valid   serial input bit valid
//   s_in_ready   driver accepts a serial input bit (registered, high in LOAD)
//   s_in_bit     serial input data, LSB first (bit i -> netlist input i)
//   dut_in       registered parallel vector driving the netlist inputs
//   dut_out      netlist outputs, combinational from dut_in
//   m_out_valid  serial output bit valid (registered, high in SHIFT)
//   m_out_ready  consumer accepts the output bit
//   m_out_bit    serial output data, LSB first (bit j -> netlist output j)
//   m_out_last   high together with the final output bit
//   busy         high whenever the driver is not loading
//   vec_count    number of completed vectors, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module bench_vector_driver #(
  parameter int IN_W   = 41,
  parameter int OUT_W  = 21,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_in_valid,
  output logic             s_in_ready,
  input  logic             s_in_bit,
  output logic [IN_W-1:0] dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             m_out_valid,
  input  logic             m_out_ready,
  output logic             m_out_bit,
  output logic             m_out_last,
  output logic             busy,
  output logic [CNT_W-1:0] vec_count
);

  // Counter width: enough to index the wider vector and to count the settle
  // interval; never narrower than one bit.
  function automatic int ctr_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

  localparam int IDX_W = ctr_width(IN_W, OUT_W, SETTLE + 1);

  localparam logic [IDX_W-1:0] IN_LAST     = IDX_W'(IN_W - 1);
  localparam logic [IDX_W-1:0] OUT_LAST    = IDX_W'(OUT_W - 1);
  localparam logic [IDX_W-1:0] SETTLE_LAST = IDX_W'(SETTLE);
  localparam logic [IDX_W-1:0] IDX_ZERO    = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_SHIFT   = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;

  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_nxt_s;
  logic [IDX_W-1:0] settle_cnt_r;
  logic [IDX_W-1:0] settle_cnt_nxt_s;

  logic [IN_W-1:0]  shadow_r;
  logic [IN_W-1:0]  load_vec_s;
  logic [IN_W-1:0]  dut_in_r;
  logic [OUT_W-1:0] out_sr_r;
  logic [CNT_W-1:0] vec_count_r;

  logic             s_in_ready_r;
  logic             m_out_valid_r;
  logic             m_out_last_r;
  logic             busy_r;

  logic             s_in_ready_nxt_s;
  logic             m_out_valid_nxt_s;
  logic             m_out_last_nxt_s;
  logic             busy_nxt_s;

  logic             in_acc_s;
  logic             in_done_s;
  logic             out_hs_s;
  logic             out_done_s;
  logic             settle_done_s;

  // Handshake and completion qualifiers shared by the FSM and datapath.
  always_comb begin
    in_acc_s      = (state_r == ST_LOAD) && s_in_valid && s_in_ready_r;
    in_done_s     = in_acc_s && (idx_r == IN_LAST);
    out_hs_s      = (state_r == ST_SHIFT) && m_out_valid_r && m_out_ready;
    out_done_s    = out_hs_s && (idx_r == OUT_LAST);
    settle_done_s = (settle_cnt_r == SETTLE_LAST);
  end

  // The shadow register fills from the top so that after IN_W accepts the
  // first received bit sits at position 0; load_vec_s already includes the
  // bit being accepted this cycle, so dut_in can be loaded in one step.
  always_comb begin
    load_vec_s = (shadow_r >> 1) | (IN_W'(s_in_bit) << (IN_W - 1));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_LOAD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic. SETTLE occupies SETTLE+1 cycles (counter 0..SETTLE),
  // so with SETTLE=0 capture follows the dut_in update after one cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (in_done_s) begin
          state_nxt_s = ST_SETTLE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_SETTLE: begin
        if (settle_done_s) begin
          state_nxt_s = ST_CAPTURE;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_CAPTURE: begin
        state_nxt_s = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (out_done_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: begin
        state_nxt_s = ST_LOAD;
      end
    endcase
  end

  // Next values of the bit index and the settle counter.
  always_comb begin
    idx_nxt_s        = idx_r;
    settle_cnt_nxt_s = IDX_ZERO;
    case (state_r)
      ST_LOAD: begin
        if (in_done_s) begin
          idx_nxt_s = IDX_ZERO;
        end else if (in_acc_s) begin
          idx_nxt_s = idx_r + IDX_ONE;
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      ST_SETTLE: begin
        idx_nxt_s = IDX_ZERO;
        if (settle_done_s) begin
          settle_cnt_nxt_s = IDX_ZERO;
        end else begin
          settle_cnt_nxt_s = settle_cnt_r + IDX_ONE;
        end
      end
      ST_CAPTURE: begin
        idx_nxt_s = IDX_ZERO;
      end
      ST_SHIFT: begin
        if (out_done_s) begin
          idx_nxt_s = IDX_ZERO;
        end else if (out_hs_s) begin
          idx_nxt_s = idx_r + IDX_ONE;
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      default: begin
        idx_nxt_s = IDX_ZERO;
      end
    endcase
  end

  // FSM output logic: outputs are decoded from the upcoming state so that
  // they can be registered and still line up with the state they describe.
  always_comb begin
    s_in_ready_nxt_s  = (state_nxt_s == ST_LOAD);
    busy_nxt_s        = (state_nxt_s != ST_LOAD);
    m_out_valid_nxt_s = (state_nxt_s == ST_SHIFT);
    m_out_last_nxt_s  = (state_nxt_s == ST_SHIFT) && (idx_nxt_s == OUT_LAST);
  end

  // Registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_in_ready_r  <= 1'b1;
      busy_r        <= 1'b0;
      m_out_valid_r <= 1'b0;
      m_out_last_r  <= 1'b0;
    end else begin
      s_in_ready_r  <= s_in_ready_nxt_s;
      busy_r        <= busy_nxt_s;
      m_out_valid_r <= m_out_valid_nxt_s;
      m_out_last_r  <= m_out_last_nxt_s;
    end
  end

  // Bit index and settle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r        <= IDX_ZERO;
      settle_cnt_r <= IDX_ZERO;
    end else begin
      idx_r        <= idx_nxt_s;
      settle_cnt_r <= settle_cnt_nxt_s;
    end
  end

  // Input side: shadow collects bits, dut_in changes only when a vector
  // completes so the netlist sees a stable previous vector while loading.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r <= '0;
      dut_in_r <= '0;
    end else begin
      if (in_acc_s) begin
        shadow_r <= load_vec_s;
      end else begin
        shadow_r <= shadow_r;
      end
      if (in_done_s) begin
        dut_in_r <= load_vec_s;
      end else begin
        dut_in_r <= dut_in_r;
      end
    end
  end

  // Output side: capture the netlist response, then shift it out LSB first.
  // Bit 0 of the shift register is the presented bit, so it stays put while
  // the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sr_r <= '0;
    end else begin
      case (state_r)
        ST_CAPTURE: out_sr_r <= dut_out;
        ST_SHIFT: begin
          if (out_hs_s) begin
            out_sr_r <= out_sr_r >> 1;
          end else begin
            out_sr_r <= out_sr_r;
          end
        end
        default: out_sr_r <= out_sr_r;
      endcase
    end
  end

  // Completed-vector counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_count_r <= '0;
    end else if (out_done_s) begin
      vec_count_r <= vec_count_r + CNT_W'(1);
    end else begin
      vec_count_r <= vec_count_r;
    end
  end

  assign s_in_ready  = s_in_ready_r;
  assign dut_in      = dut_in_r;
  assign m_out_valid = m_out_valid_r;
  assign m_out_bit   = out_sr_r[0];
  assign m_out_last  = m_out_last_r;
  assign busy        = busy_r;
  assign vec_count   = vec_count_r;

endmodule

// File: tb/tb_bench_vector_driver.sv
// Testbench for bench_vector_driver: two instances (SETTLE=2/CNT_W=16 and
// SETTLE=0/CNT_W=4) driven one at a time against a vector-level model.
module tb_bench_vector_driver;

  localparam int IN_W  = 41;
  localparam int OUT_W = 21;
  localparam logic [20:0] NET_MASK = 21'h0F0F0;
  localparam logic [40:0] VEC_A    = 41'h155_5555_5555;

  logic        clk;
  logic        rst         [2];
  logic        s_in_valid  [2];
  logic        s_in_ready  [2];
  logic        s_in_bit    [2];
  logic [40:0] dut_in      [2];
  logic [20:0] dut_out     [2];
  logic        m_out_valid [2];
  logic        m_out_ready [2];
  logic        m_out_bit   [2];
  logic        m_out_last  [2];
  logic        busy        [2];
  logic [15:0] vec_count0;
  logic [3:0]  vec_count1;

  int n_checks = 0;
  int n_errors = 0;

  logic [40:0] prev_vec  [2];
  int          cnt_model [2];

  // Netlist model: combinational from dut_in.
  assign dut_out[0] = dut_in[0][20:0] ^ NET_MASK;
  assign dut_out[1] = dut_in[1][20:0] ^ NET_MASK;

  bench_vector_driver #(.IN_W(41), .OUT_W(21), .SETTLE(2), .CNT_W(16)) u_drv_s2 (
    .clk(clk), .rst(rst[0]),
    .s_in_valid(s_in_valid[0]), .s_in_ready(s_in_ready[0]), .s_in_bit(s_in_bit[0]),
    .dut_in(dut_in[0]), .dut_out(dut_out[0]),
    .m_out_valid(m_out_valid[0]), .m_out_ready(m_out_ready[0]),
    .m_out_bit(m_out_bit[0]), .m_out_last(m_out_last[0]),
    .busy(busy[0]), .vec_count(vec_count0)
  );

  bench_vector_driver #(.IN_W(41), .OUT_W(21), .SETTLE(0), .CNT_W(4)) u_drv_s0 (
    .clk(clk), .rst(rst[1]),
    .s_in_valid(s_in_valid[1]), .s_in_ready(s_in_ready[1]), .s_in_bit(s_in_bit[1]),
    .dut_in(dut_in[1]), .dut_out(dut_out[1]),
    .m_out_valid(m_out_valid[1]), .m_out_ready(m_out_ready[1]),
    .m_out_bit(m_out_bit[1]), .m_out_last(m_out_last[1]),
    .busy(busy[1]), .vec_count(vec_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int settle_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int cnt_mod(input int d);
    return (d == 0) ? 65536 : 16;
  endfunction

  function automatic int get_cnt(input int d);
    return (d == 0) ? int'(vec_count0) : int'(vec_count1);
  endfunction

  function automatic logic [40:0] rand_vec();
    logic [8:0]  hi;
    logic [31:0] lo;
    hi = 9'($urandom);
    lo = $urandom;
    return {hi, lo};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse reset for one edge and check every output returns to its reset value.
  task automatic apply_reset(input int d);
    rst[d]         = 1'b1;
    s_in_valid[d]  = 1'b0;
    m_out_ready[d] = 1'b0;
    @(negedge clk);
    check_eq("rst_ready",  s_in_ready[d],  1);
    check_eq("rst_valid",  m_out_valid[d], 0);
    check_eq("rst_bit",    m_out_bit[d],   0);
    check_eq("rst_last",   m_out_last[d],  0);
    check_eq("rst_busy",   busy[d],        0);
    check_eq("rst_count",  get_cnt(d),     0);
    check_eq("rst_dut_in", dut_in[d],      0);
    rst[d]       = 1'b0;
    prev_vec[d]  = '0;
    cnt_model[d] = 0;
  endtask

  // One full vector transaction; rst_in / rst_out (>=0) abort with reset at
  // that input / output bit index.
  task automatic run_vector(input int d, input logic [40:0] vec, input bit stall,
                            input int rst_in, input int rst_out);
    int i, j, guard, pre, low, shift_cyc;
    logic acc, hs, held_bit;
    bit was_stall;
    logic [20:0] exp_out;
    exp_out = vec[20:0] ^ NET_MASK;

    i = 0; guard = 0;
    while (i < IN_W && guard < 400) begin
      if (i == rst_in) begin
        apply_reset(d);
        return;
      end
      if (i == IN_W - 1) check_eq("hold_dut_in", dut_in[d], prev_vec[d]);
      s_in_valid[d] = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_in_bit[d]   = vec[i];
      acc = s_in_valid[d] & s_in_ready[d];
      @(negedge clk);
      if (acc) i++;
      guard++;
    end
    if (i != IN_W) begin
      check_eq("load_timeout", i, IN_W);
      return;
    end
    prev_vec[d] = vec;
    check_eq("dut_in_applied", dut_in[d], vec);
    check_eq("busy_after_load", busy[d], 1);

    // Keep valid high with junk bits: these must be ignored.
    s_in_valid[d]  = 1'b1;
    m_out_ready[d] = 1'b0;
    pre = 0; low = 0;
    while (!m_out_valid[d] && pre < 50) begin
      if (!s_in_ready[d]) low++;
      s_in_bit[d] = 1'($urandom_range(0, 1));
      @(negedge clk);
      pre++;
    end
    if (!m_out_valid[d]) begin
      check_eq("valid_timeout", m_out_valid[d], 1);
      return;
    end
    check_eq("pre_valid_cycles", pre, settle_of(d) + 2);

    j = 0; shift_cyc = 0; was_stall = 0; held_bit = 1'b0;
    while (j < OUT_W && shift_cyc < 400) begin
      if (j == rst_out) begin
        apply_reset(d);
        return;
      end
      if (!s_in_ready[d]) low++;
      check_eq("out_valid", m_out_valid[d], 1);
      if (was_stall) check_eq("stall_hold", m_out_bit[d], held_bit);
      check_eq($sformatf("out_bit%0d", j), m_out_bit[d], exp_out[j]);
      check_eq($sformatf("out_last%0d", j), m_out_last[d], (j == OUT_W - 1));
      s_in_bit[d]    = 1'($urandom_range(0, 1));
      m_out_ready[d] = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      hs        = m_out_valid[d] & m_out_ready[d];
      was_stall = m_out_valid[d] & ~m_out_ready[d];
      held_bit  = m_out_bit[d];
      @(negedge clk);
      shift_cyc++;
      if (hs) j++;
    end
    if (j != OUT_W) begin
      check_eq("shift_timeout", j, OUT_W);
      return;
    end
    s_in_valid[d]  = 1'b0;
    m_out_ready[d] = 1'b0;
    cnt_model[d] = (cnt_model[d] + 1) % cnt_mod(d);
    check_eq("end_valid", m_out_valid[d], 0);
    check_eq("end_last",  m_out_last[d],  0);
    check_eq("end_ready", s_in_ready[d],  1);
    check_eq("end_busy",  busy[d],        0);
    check_eq("ready_low_span", low, pre + shift_cyc);
    if (!stall) check_eq("ready_low_cycles", low, settle_of(d) + 2 + OUT_W);
    check_eq("vec_count", get_cnt(d), cnt_model[d]);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; s_in_valid[d] = 1'b0; s_in_bit[d] = 1'b0;
      m_out_ready[d] = 1'b0; prev_vec[d] = '0; cnt_model[d] = 0;
    end
    repeat (2) @(negedge clk);
    apply_reset(0);
    apply_reset(1);

    run_vector(0, VEC_A, 1'b0, -1, -1);
    run_vector(0, VEC_A, 1'b1, -1, -1);
    for (int k = 0; k < 4; k++) run_vector(0, rand_vec(), 1'b1, -1, -1);

    run_vector(1, VEC_A, 1'b0, -1, -1);

    run_vector(0, rand_vec(), 1'b0, 9, -1);
    run_vector(0, rand_vec(), 1'b1, -1, -1);
    run_vector(0, rand_vec(), 1'b1, -1, 4);
    run_vector(0, rand_vec(), 1'b0, -1, -1);

    apply_reset(1);
    for (int k = 0; k < 17; k++) run_vector(1, rand_vec(), k[0], -1, -1);
    check_eq("wrap_count", get_cnt(1), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
